barrier_ctl_unit: RTL and testbench
===================================

Name: barrier_ctl_unit

Overview:
- Consumes the barrier portion of the warp-control bus (valid, wid, barrier op, barrier id, size) issued by the SFU warp-control stage.
- Tracks per-barrier arrival counts, waiting-warp masks and generation tokens.
- Drives registered release pulses and a stall mask to the warp scheduler.
- Serves the combinational async-barrier token lookup (barrier id in, arrive token out) back to the warp-control stage.

Parameters:
- NUM_WARPS, 4, number of warps per core; NW_WIDTH = max(1, clog2(NUM_WARPS))
- NUM_BARRIERS, 4, number of barrier slots; NB_WIDTH = max(1, clog2(NUM_BARRIERS))
- TOKEN_W, 32, generation token width (XLEN in the core)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  barrier request valid (one per cycle max)
- req_ready  out  1  request accepted; 0 while reset asserted, 1 otherwise
- req_wid  in  NW_WIDTH  requesting warp
- req_id  in  NB_WIDTH  barrier id
- req_op  in  2  00 SYNC, 01 ARRIVE, 10 WAIT, 11 reserved
- req_size_m1  in  NW_WIDTH  participating warps minus one
- req_token  in  TOKEN_W  token for WAIT
- rd_id  in  NB_WIDTH  token lookup id
- rd_token  out  TOKEN_W  current generation of rd_id (combinational from registers)
- release_valid  out  1  release pulse
- release_mask  out  NUM_WARPS  warps released
- stalled_mask  out  NUM_WARPS  warps currently blocked on any barrier

Behaviour:
- Reset (async, reset==0): all counts 0, waiting masks 0, generations 0, release_valid 0, release_mask 0, stalled_mask 0. Mid-operation reset drops all waiters; no release pulse is emitted.
- Handshake: a request is taken on a clk edge with req_valid && req_ready. All state updates land on that edge.
- Per barrier state:
  - cnt[b], width NW_WIDTH+1
  - wait[b], NUM_WARPS bits
  - gen[b], TOKEN_W bits
- Completion test: (cnt[id]+1) > req_size_m1. Uses >=, so inconsistent sizes still complete. The size of the completing request governs.
- SYNC:
  - If wait[id][wid] is already set: duplicate, no effect.
  - Else if completing: gen[id]+=1, cnt[id]=0, wait[id]=0; release_mask <= old wait[id] | onehot(wid), release_valid <= 1.
  - Else: cnt[id]+=1, wait[id][wid]=1.
- ARRIVE: same counting as SYNC but the warp never waits.
  - On completion, release_mask <= old wait[id]; release_valid <= (mask != 0).
  - Non-completing ARRIVE only increments cnt.
- WAIT:
  - If req_token != gen[id]: the barrier has already advanced; no effect.
  - Else: wait[id][wid]=1. cnt is unchanged and a WAIT never completes a barrier.
- Reserved op: no effect.
- Latency:
  - Release is visible the cycle after the completing request is accepted.
  - stalled_mask is registered, equals OR of all wait[b], and is updated on the same edge. A SYNC's own warp bit therefore never appears in stalled_mask on completion.
- release_valid is a 1-cycle pulse, cleared the next cycle unless another completion occurs.
- rd_token returns the pre-update gen. A same-cycle lookup during completion returns the old value; the new value is visible the next cycle.
- gen wraps modulo 2^TOKEN_W.
- No simultaneous requests exist. Completions on different barriers in consecutive cycles produce back-to-back pulses.

Test Plan:
1. SYNC id0 size_m1=2 from w0,w1,w2 on consecutive cycles -> stalled_mask 0001 then 0011; after w2, next cycle release_valid=1, release_mask=0111, stalled_mask=0000, rd_token(id0)=1.
2. ARRIVE id1 size_m1=3 from w0,w2,w3 (rd_token=0 each) with WAIT w1 token 0 between -> stalled_mask 0010; after 4th ARRIVE (w0 again) release_mask=0010, rd_token(id1)=1.
3. gen[id2]=1, WAIT w3 token 0 -> no stall, stalled_mask 0000, no release pulse.
4. Duplicate SYNC w0 twice on id3 size_m1=1 -> no release, cnt stays 1; SYNC w1 -> release_mask=0011.
5. TOKEN_W=4, 16 completions of SYNC id0 size_m1=0 -> rd_token counts 1..15 then wraps to 0; 16 release pulses, each mask = onehot(wid).
6. w0,w1 stalled on id0 (mask 0011), assert reset low mid-cycle -> stalled_mask 0000 immediately, req_ready 0; after release, rd_token=0 all ids, no release pulse ever.

Source files
------------

// File: rtl/barrier_ctl_unit_if.sv
// Barrier request bus from the SFU warp-control stage to the barrier unit.
interface barrier_ctl_unit_if #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_BARRIERS = 4,
    parameter int TOKEN_W      = 32
);
    localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int NB_WIDTH = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

    logic                req_valid;
    logic                req_ready;
    logic [NW_WIDTH-1:0] req_wid;
    logic [NB_WIDTH-1:0] req_id;
    logic [1:0]          req_op;
    logic [NW_WIDTH-1:0] req_size_m1;
    logic [TOKEN_W-1:0]  req_token;

    modport master (
        output req_valid, req_wid, req_id, req_op, req_size_m1, req_token,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_wid, req_id, req_op, req_size_m1, req_token,
        output req_ready
    );
endinterface

// File: rtl/barrier_ctl_unit.sv
// Barrier control unit: per-barrier arrival counts, waiting masks and
// generation tokens; registered release pulses and stall mask.
module barrier_ctl_unit #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_BARRIERS = 4,
    parameter int TOKEN_W      = 32,
    localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int NB_WIDTH    = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    barrier_ctl_unit_if.slave     req,
    input  logic [NB_WIDTH-1:0]   rd_id,
    output logic [TOKEN_W-1:0]    rd_token,
    output logic                  release_valid,
    output logic [NUM_WARPS-1:0]  release_mask,
    output logic [NUM_WARPS-1:0]  stalled_mask
);
    typedef enum logic [1:0] {
        OP_SYNC   = 2'b00,
        OP_ARRIVE = 2'b01,
        OP_WAIT   = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    logic [NW_WIDTH:0]    cnt_q  [NUM_BARRIERS];
    logic [NW_WIDTH:0]    cnt_d  [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] wait_q [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] wait_d [NUM_BARRIERS];
    logic [TOKEN_W-1:0]   gen_q  [NUM_BARRIERS];
    logic [TOKEN_W-1:0]   gen_d  [NUM_BARRIERS];

    logic                 take;
    logic [NUM_WARPS-1:0] wid_oh;
    logic [NW_WIDTH:0]    cur_cnt;
    logic [NUM_WARPS-1:0] cur_wait;
    logic [TOKEN_W-1:0]   cur_gen;
    logic [NW_WIDTH+1:0]  cnt_inc;
    logic                 complete;
    logic                 rel_valid_d;
    logic [NUM_WARPS-1:0] rel_mask_d;
    logic [NUM_WARPS-1:0] stall_d;

    assign req.req_ready = reset;
    assign take          = req.req_valid && req.req_ready;
    assign rd_token      = gen_q[rd_id];

    // Next-state for the addressed barrier, release outputs and stall mask.
    always_comb begin
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        gen_d       = gen_q;
        rel_valid_d = 1'b0;
        rel_mask_d  = '0;
        wid_oh      = NUM_WARPS'(1) << req.req_wid;
        cur_cnt     = cnt_q[req.req_id];
        cur_wait    = wait_q[req.req_id];
        cur_gen     = gen_q[req.req_id];
        cnt_inc     = {1'b0, cur_cnt} + (NW_WIDTH+2)'(1);
        complete    = cnt_inc > {2'b00, req.req_size_m1};

        if (take) begin
            case (op_e'(req.req_op))
                OP_SYNC: begin
                    if (!cur_wait[req.req_wid]) begin
                        if (complete) begin
                            gen_d[req.req_id]  = cur_gen + TOKEN_W'(1);
                            cnt_d[req.req_id]  = '0;
                            wait_d[req.req_id] = '0;
                            rel_valid_d        = 1'b1;
                            rel_mask_d         = cur_wait | wid_oh;
                        end else begin
                            cnt_d[req.req_id]  = cnt_inc[NW_WIDTH:0];
                            wait_d[req.req_id] = cur_wait | wid_oh;
                        end
                    end
                end
                OP_ARRIVE: begin
                    if (complete) begin
                        gen_d[req.req_id]  = cur_gen + TOKEN_W'(1);
                        cnt_d[req.req_id]  = '0;
                        wait_d[req.req_id] = '0;
                        rel_valid_d        = |cur_wait;
                        rel_mask_d         = cur_wait;
                    end else begin
                        cnt_d[req.req_id] = cnt_inc[NW_WIDTH:0];
                    end
                end
                OP_WAIT: begin
                    if (req.req_token == cur_gen) begin
                        wait_d[req.req_id] = cur_wait | wid_oh;
                    end
                end
                default: ;
            endcase
        end

        stall_d = '0;
        for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
            stall_d = stall_d | wait_d[b];
        end
    end

    // Barrier state and scheduler-facing outputs; reset drops all waiters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
                cnt_q[b]  <= '0;
                wait_q[b] <= '0;
                gen_q[b]  <= '0;
            end
            release_valid <= 1'b0;
            release_mask  <= '0;
            stalled_mask  <= '0;
        end else begin
            cnt_q         <= cnt_d;
            wait_q        <= wait_d;
            gen_q         <= gen_d;
            release_valid <= rel_valid_d;
            release_mask  <= rel_mask_d;
            stalled_mask  <= stall_d;
        end
    end
endmodule

// File: tb/tb_barrier_ctl_unit.sv
// Self-checking bench for barrier_ctl_unit: vector table with a scoreboard
// plus hand-written sequences for token lookup timing, wrap and reset.
module tb_barrier_ctl_unit;
    localparam logic [1:0] SYNC = 2'b00, ARRV = 2'b01, WAIT = 2'b10, RSVD = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  rd_id, w_rd_id;
    logic [31:0] rd_token;
    logic [3:0]  w_rd_token;
    logic        release_valid, w_release_valid;
    logic [3:0]  release_mask, stalled_mask, w_release_mask, w_stalled_mask;

    always #5 clk = ~clk;

    barrier_ctl_unit_if #(.NUM_WARPS(4), .NUM_BARRIERS(4), .TOKEN_W(32)) bif ();
    barrier_ctl_unit_if #(.NUM_WARPS(4), .NUM_BARRIERS(4), .TOKEN_W(4))  wif ();

    barrier_ctl_unit #(.NUM_WARPS(4), .NUM_BARRIERS(4), .TOKEN_W(32)) dut (
        .clk(clk), .reset(reset), .req(bif), .rd_id(rd_id), .rd_token(rd_token),
        .release_valid(release_valid), .release_mask(release_mask),
        .stalled_mask(stalled_mask)
    );

    barrier_ctl_unit #(.NUM_WARPS(4), .NUM_BARRIERS(4), .TOKEN_W(4)) dut_w (
        .clk(clk), .reset(reset), .req(wif), .rd_id(w_rd_id), .rd_token(w_rd_token),
        .release_valid(w_release_valid), .release_mask(w_release_mask),
        .stalled_mask(w_stalled_mask)
    );

    typedef struct {
        logic        valid;
        logic [1:0]  op, wid, id, sz;
        logic [31:0] tok;
        logic        ev;
        logic [3:0]  em, es;
        logic [31:0] eg;
    } vec_t;

    typedef struct {
        int          idx;
        logic        ev;
        logic [3:0]  em, es;
        logic [31:0] eg;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t e;
    int   compared = 0;
    int   mismatched = 0;
    int   pulses;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        compared++;
        if (act !== req_v) begin
            mismatched++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [1:0] op, wid, id, sz,
                                input logic [31:0] tok, input logic ev,
                                input logic [3:0] em, es, input logic [31:0] eg);
        vec_t r;
        r.valid = v; r.op = op; r.wid = wid; r.id = id; r.sz = sz; r.tok = tok;
        r.ev = ev; r.em = em; r.es = es; r.eg = eg;
        return r;
    endfunction

    task automatic drive(input int idx, input vec_t v);
        exp_t x;
        @(negedge clk);
        bif.req_valid   = v.valid;
        bif.req_op      = v.op;
        bif.req_wid     = v.wid;
        bif.req_id      = v.id;
        bif.req_size_m1 = v.sz;
        bif.req_token   = v.tok;
        rd_id           = v.id;
        x.idx = idx; x.ev = v.ev; x.em = v.em; x.es = v.es; x.eg = v.eg;
        sb.push_back(x);
    endtask

    // Scoreboard: each accepted vector's effect is compared just after its edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("v%0d release_valid", e.idx), 32'(release_valid), 32'(e.ev));
            if (e.ev) check($sformatf("v%0d release_mask", e.idx), 32'(release_mask), 32'(e.em));
            check($sformatf("v%0d stalled_mask", e.idx), 32'(stalled_mask), 32'(e.es));
            check($sformatf("v%0d rd_token", e.idx), rd_token, e.eg);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.req_valid = 1'b0; bif.req_op = SYNC; bif.req_wid = '0; bif.req_id = '0;
        bif.req_size_m1 = '0; bif.req_token = '0; rd_id = '0;
        wif.req_valid = 1'b0; wif.req_op = SYNC; wif.req_wid = '0; wif.req_id = '0;
        wif.req_size_m1 = '0; wif.req_token = '0; w_rd_id = '0;

        // Reset state
        #2 reset = 1'b0;
        #1;
        check("reset req_ready", 32'(bif.req_ready), 32'd0);
        check("reset release_valid", 32'(release_valid), 32'd0);
        check("reset release_mask", 32'(release_mask), 32'd0);
        check("reset stalled_mask", 32'(stalled_mask), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("ready after reset", 32'(bif.req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            rd_id = 2'(i);
            #1 check($sformatf("reset gen id%0d", i), rd_token, 32'd0);
        end

        //              v  op    w  id sz tok  ev em    es     eg
        vecs.push_back(mk(1, SYNC, 0, 0, 2, 0, 0, 4'h0, 4'h1, 0));
        vecs.push_back(mk(1, SYNC, 1, 0, 2, 0, 0, 4'h0, 4'h3, 0));
        vecs.push_back(mk(1, SYNC, 2, 0, 2, 0, 1, 4'h7, 4'h0, 1));
        vecs.push_back(mk(0, SYNC, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1));
        vecs.push_back(mk(1, ARRV, 0, 1, 3, 0, 0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(1, WAIT, 1, 1, 0, 0, 0, 4'h0, 4'h2, 0));
        vecs.push_back(mk(1, ARRV, 2, 1, 3, 0, 0, 4'h0, 4'h2, 0));
        vecs.push_back(mk(1, ARRV, 3, 1, 3, 0, 0, 4'h0, 4'h2, 0));
        vecs.push_back(mk(1, ARRV, 0, 1, 3, 0, 1, 4'h2, 4'h0, 1));
        vecs.push_back(mk(1, ARRV, 0, 2, 0, 0, 0, 4'h0, 4'h0, 1));
        vecs.push_back(mk(1, WAIT, 3, 2, 0, 0, 0, 4'h0, 4'h0, 1));
        vecs.push_back(mk(1, WAIT, 3, 2, 0, 1, 0, 4'h0, 4'h8, 1));
        vecs.push_back(mk(1, ARRV, 0, 2, 0, 0, 1, 4'h8, 4'h0, 2));
        vecs.push_back(mk(1, SYNC, 0, 3, 1, 0, 0, 4'h0, 4'h1, 0));
        vecs.push_back(mk(1, SYNC, 0, 3, 1, 0, 0, 4'h0, 4'h1, 0));
        vecs.push_back(mk(1, SYNC, 1, 3, 1, 0, 1, 4'h3, 4'h0, 1));
        vecs.push_back(mk(1, SYNC, 0, 3, 2, 0, 0, 4'h0, 4'h1, 1));
        vecs.push_back(mk(1, SYNC, 0, 3, 2, 0, 0, 4'h0, 4'h1, 1));
        vecs.push_back(mk(1, SYNC, 1, 3, 2, 0, 0, 4'h0, 4'h3, 1));
        vecs.push_back(mk(1, SYNC, 2, 3, 2, 0, 1, 4'h7, 4'h0, 2));
        vecs.push_back(mk(1, SYNC, 2, 0, 0, 0, 1, 4'h4, 4'h0, 2));
        vecs.push_back(mk(1, SYNC, 3, 1, 0, 0, 1, 4'h8, 4'h0, 2));
        vecs.push_back(mk(1, RSVD, 0, 0, 0, 0, 0, 4'h0, 4'h0, 2));
        vecs.push_back(mk(1, SYNC, 0, 2, 3, 0, 0, 4'h0, 4'h1, 2));
        vecs.push_back(mk(1, SYNC, 1, 2, 1, 0, 1, 4'h3, 4'h0, 3));
        vecs.push_back(mk(0, SYNC, 0, 2, 0, 0, 0, 4'h0, 4'h0, 3));

        foreach (vecs[i]) drive(i, vecs[i]);
        @(negedge clk);
        bif.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        // Same-cycle lookup during completion returns the pre-update generation
        bif.req_valid = 1'b1; bif.req_op = SYNC; bif.req_wid = 2'd0;
        bif.req_id = 2'd0; bif.req_size_m1 = 2'd0; rd_id = 2'd0;
        #1 check("pre-update rd_token", rd_token, 32'd2);
        @(posedge clk); #1;
        check("post-update rd_token", rd_token, 32'd3);
        check("solo release_valid", 32'(release_valid), 32'd1);
        check("solo release_mask", 32'(release_mask), 32'h1);
        @(negedge clk);
        bif.req_valid = 1'b0;
        @(posedge clk); #1;
        check("pulse cleared", 32'(release_valid), 32'd0);

        // 4-bit generation wraps after 16 completions
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wif.req_valid = 1'b1; wif.req_op = SYNC; wif.req_wid = 2'(i % 4);
            wif.req_id = 2'd0; wif.req_size_m1 = 2'd0; w_rd_id = 2'd0;
            @(posedge clk); #1;
            if (w_release_valid) pulses++;
            check($sformatf("wrap%0d release_mask", i), 32'(w_release_mask), 32'(4'b0001 << (i % 4)));
            check($sformatf("wrap%0d rd_token", i), 32'(w_rd_token), 32'((i + 1) % 16));
        end
        @(negedge clk);
        wif.req_valid = 1'b0;
        check("wrap pulse count", 32'(pulses), 32'd16);

        // Mid-operation reset drops waiters without a release pulse
        bif.req_valid = 1'b1; bif.req_op = SYNC; bif.req_wid = 2'd0;
        bif.req_id = 2'd0; bif.req_size_m1 = 2'd3;
        @(negedge clk);
        bif.req_wid = 2'd1;
        @(posedge clk); #1;
        check("pre-reset stalled_mask", 32'(stalled_mask), 32'h3);
        @(negedge clk);
        bif.req_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid-reset stalled_mask", 32'(stalled_mask), 32'h0);
        check("mid-reset req_ready", 32'(bif.req_ready), 32'd0);
        pulses = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (release_valid) pulses++;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (release_valid) pulses++;
        end
        check("reset release pulses", 32'(pulses), 32'd0);
        check("post-reset stalled_mask", 32'(stalled_mask), 32'h0);
        for (int i = 0; i < 4; i++) begin
            rd_id = 2'(i);
            #1 check($sformatf("post-reset gen id%0d", i), rd_token, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
